saturate_10to8: RTL and testbench

Clamps a wide unsigned (or optionally signed) filter result into an 8-bit pixel value. Each colour channel of the 5x5 Gaussian filter path has one instance, fed the scaled accumulator slice (accumulator bits [19:10]). The output is registered with one-cycle latency, and the block provides per-sample clip flags plus sticky and counted clip statistics for debug.

---
 rtl/saturate_10to8.sv | 73 +++++++
 tb/tb_saturate_10to8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/saturate_10to8.sv
// Registered clamp of a wide (optionally signed) filter result into an OUT_W-bit pixel,
// with per-sample clip flags and sticky/counted clip statistics for debug.
module saturate_10to8 #(
    parameter int IN_W      = 10,
    parameter int OUT_W     = 8,
    parameter int SIGNED_IN = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    input  logic             clr_stats,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [IN_W-1:0] MAX_IN = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [OUT_W-1:0] result;
    logic             clip_hi;
    logic             clip_lo;
    logic             clip_any;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        result  = in[OUT_W-1:0];
        clip_hi = 1'b0;
        clip_lo = 1'b0;
        if ((SIGNED_IN != 0) && in[IN_W-1]) begin
            result  = '0;
            clip_lo = 1'b1;
        end else if (in > MAX_IN) begin
            result  = '1;
            clip_hi = 1'b1;
        end
    end

    assign clip_any = in_valid && (clip_hi || clip_lo);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            sat_hi    <= in_valid && clip_hi;
            sat_lo    <= in_valid && clip_lo;
            if (in_valid)
                out <= result;
        end
    end

    // Clear beats a simultaneous clip; the counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (clip_any) begin
            sat_sticky <= 1'b1;
            if (sat_count != '1)
                sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_saturate_10to8.sv
// Directed self-checking bench for saturate_10to8: default, signed-input and narrow-counter
// instances driven from one linear stimulus sequence.
module tb_saturate_10to8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Default instance
    logic       d_valid, d_clr;
    logic [9:0] d_in;
    logic [7:0] d_out;
    logic       d_ov, d_hi, d_lo, d_sticky;
    logic [15:0] d_cnt;

    // Signed-input instance
    logic       s_valid, s_clr;
    logic [9:0] s_in;
    logic [7:0] s_out;
    logic       s_ov, s_hi, s_lo, s_sticky;
    logic [15:0] s_cnt;

    // Narrow-counter instance
    logic       c_valid, c_clr;
    logic [9:0] c_in;
    logic [7:0] c_out;
    logic       c_ov, c_hi, c_lo, c_sticky;
    logic [2:0] c_cnt;

    saturate_10to8 u_dut (
        .clk(clk), .rst(rst), .in_valid(d_valid), .in(d_in), .clr_stats(d_clr),
        .out(d_out), .out_valid(d_ov), .sat_hi(d_hi), .sat_lo(d_lo),
        .sat_sticky(d_sticky), .sat_count(d_cnt)
    );

    saturate_10to8 #(.SIGNED_IN(1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in(s_in), .clr_stats(s_clr),
        .out(s_out), .out_valid(s_ov), .sat_hi(s_hi), .sat_lo(s_lo),
        .sat_sticky(s_sticky), .sat_count(s_cnt)
    );

    saturate_10to8 #(.CNT_W(3)) u_cnt (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in(c_in), .clr_stats(c_clr),
        .out(c_out), .out_valid(c_ov), .sat_hi(c_hi), .sat_lo(c_lo),
        .sat_sticky(c_sticky), .sat_count(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d(input string tag, input logic [7:0] e_out, input logic e_ov,
                           input logic e_hi);
        check({tag, ".out"}, 32'(d_out), 32'(e_out));
        check({tag, ".out_valid"}, 32'(d_ov), 32'(e_ov));
        check({tag, ".sat_hi"}, 32'(d_hi), 32'(e_hi));
        check({tag, ".sat_lo"}, 32'(d_lo), 32'd0);
    endtask

    initial begin
        int unsigned   u_in [6]  = '{0, 1, 200, 255, 256, 1023};
        int unsigned   u_out[6]  = '{0, 1, 200, 255, 255, 255};
        int unsigned   u_hi [6]  = '{0, 0, 0, 0, 1, 1};
        int unsigned   g_in [4]  = '{10'h3FF, 10'h200, 10'h0FF, 10'h1FF};
        int unsigned   g_out[4]  = '{0, 0, 255, 255};
        int unsigned   g_lo [4]  = '{1, 1, 0, 0};
        int unsigned   g_hi [4]  = '{0, 0, 0, 1};

        rst = 1'b1;
        d_valid = 1'b1; d_in = 10'd999; d_clr = 1'b0;
        s_valid = 1'b1; s_in = 10'h3FF;  s_clr = 1'b0;
        c_valid = 1'b1; c_in = 10'd1000; c_clr = 1'b0;
        tick();
        tick();

        // Reset state, with clipping valid inputs present to prove reset priority
        check_d("reset", 8'd0, 1'b0, 1'b0);
        check("reset.sticky", 32'(d_sticky), 32'd0);
        check("reset.count", 32'(d_cnt), 32'd0);
        check("reset.sgn_lo", 32'(s_lo), 32'd0);
        check("reset.cnt_count", 32'(c_cnt), 32'd0);

        s_valid = 1'b0;
        c_valid = 1'b0;
        rst = 1'b0;

        // 1: unsigned sweep including MAX and MAX+1 boundaries
        for (int i = 0; i < 6; i++) begin
            d_valid = 1'b1;
            d_in    = 10'(u_in[i]);
            tick();
            check_d($sformatf("sweep%0d", i), 8'(u_out[i]), 1'b1, 1'(u_hi[i]));
        end
        check("sweep.count", 32'(d_cnt), 32'd2);
        check("sweep.sticky", 32'(d_sticky), 32'd1);

        // Clear stats with no valid sample
        d_valid = 1'b0;
        d_clr   = 1'b1;
        tick();
        d_clr = 1'b0;
        check("clr.count", 32'(d_cnt), 32'd0);
        check("clr.sticky", 32'(d_sticky), 32'd0);
        check("clr.out_hold", 32'(d_out), 32'd255);

        // 2: in_valid toggling; invalid sample neither updates out nor counts
        d_valid = 1'b1; d_in = 10'd300;
        tick();
        check_d("tog0", 8'd255, 1'b1, 1'b1);
        d_valid = 1'b0; d_in = 10'd5;
        tick();
        check_d("tog1", 8'd255, 1'b0, 1'b0);
        d_valid = 1'b1; d_in = 10'd17;
        tick();
        check_d("tog2", 8'd17, 1'b1, 1'b0);
        check("tog.count", 32'(d_cnt), 32'd1);
        check("tog.sticky", 32'(d_sticky), 32'd1);

        // 4: clear wins over a simultaneous clipping valid sample
        d_valid = 1'b1; d_in = 10'd400; d_clr = 1'b1;
        tick();
        d_clr = 1'b0;
        check_d("clrwin", 8'd255, 1'b1, 1'b1);
        check("clrwin.sticky", 32'(d_sticky), 32'd0);
        check("clrwin.count", 32'(d_cnt), 32'd0);
        d_valid = 1'b0;

        // 3: signed mode, negative inputs clip low
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_in    = 10'(g_in[i]);
            tick();
            check($sformatf("sgn%0d.out", i), 32'(s_out), g_out[i]);
            check($sformatf("sgn%0d.sat_lo", i), 32'(s_lo), g_lo[i]);
            check($sformatf("sgn%0d.sat_hi", i), 32'(s_hi), g_hi[i]);
        end
        s_valid = 1'b0;
        check("sgn.count", 32'(s_cnt), 32'd3);
        check("sgn.sticky", 32'(s_sticky), 32'd1);
        s_in = 10'd0;
        tick();
        check("sgn.lo_drop", 32'(s_lo), 32'd0);
        check("sgn.valid_drop", 32'(s_ov), 32'd0);

        // 3b: zero passes unclipped in signed mode
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("sgn.zero_out", 32'(s_out), 32'd0);
        check("sgn.zero_lo", 32'(s_lo), 32'd0);
        check("sgn.zero_count", 32'(s_cnt), 32'd3);

        // 5: narrow counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            c_valid = 1'b1;
            c_in    = 10'd1000;
            tick();
            check($sformatf("cnt%0d", i), 32'(c_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        c_valid = 1'b0;
        check("cnt.out", 32'(c_out), 32'd255);

        // 6: reset mid-stream
        d_valid = 1'b1; d_in = 10'd999;
        tick();
        tick();
        check("pre_rst.count", 32'(d_cnt), 32'd2);
        rst = 1'b1;
        tick();
        check_d("midrst", 8'd0, 1'b0, 1'b0);
        check("midrst.sticky", 32'(d_sticky), 32'd0);
        check("midrst.count", 32'(d_cnt), 32'd0);
        check("midrst.cnt_count", 32'(c_cnt), 32'd0);
        rst = 1'b0;
        d_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
